// File: rtl/sweep_pkg.sv
// Shared types and helpers for the frequency-sweep scheduler.
// Optional feature macro: SWEEP_TRIANGLE_EN (phase-continuous bounce in repeat mode).
package sweep_pkg;

  localparam int SWEEP_WIDTH   = 8;
  localparam int SWEEP_DWELL_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    STEP = 2'd3
  } sweep_state_t;

  // Registered sweep configuration; dir_down is derived once at load time.
  typedef struct packed {
    logic [SWEEP_WIDTH-1:0]   f_start;
    logic [SWEEP_WIDTH-1:0]   f_stop;
    logic [SWEEP_WIDTH-1:0]   step;
    logic [SWEEP_DWELL_W-1:0] dwell;
    logic                     repeat_mode;
    logic                     dir_down;
  } sweep_cfg_t;

  // Move cur one step toward stop. The arithmetic is one bit wider so a wrap
  // past 0 or the top of the range is seen and clamped to stop, as is any
  // overshoot of stop itself.
  function automatic logic [SWEEP_WIDTH-1:0] step_toward(
    input logic [SWEEP_WIDTH-1:0] cur,
    input logic [SWEEP_WIDTH-1:0] stop,
    input logic [SWEEP_WIDTH-1:0] stp,
    input logic                   down
  );
    logic [SWEEP_WIDTH:0]   sum;
    logic [SWEEP_WIDTH-1:0] res;
    if (down) begin
      sum = {1'b0, cur} - {1'b0, stp};
      res = (sum[SWEEP_WIDTH] || (sum[SWEEP_WIDTH-1:0] < stop)) ? stop : sum[SWEEP_WIDTH-1:0];
    end else begin
      sum = {1'b0, cur} + {1'b0, stp};
      res = (sum[SWEEP_WIDTH] || (sum[SWEEP_WIDTH-1:0] > stop)) ? stop : sum[SWEEP_WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/sweep_ctrl_dwell_timer.sv
// Loadable dwell down-counter. A load of 0 is treated as 1 so every
// frequency gets at least one enabled cycle. expire is high during the
// last enabled cycle of the period.
module dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt;

  assign expire = en && (cnt == W'(1));

  // Load has priority; otherwise count down while enabled and stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (value == '0) ? W'(1) : value;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency-sweep scheduler driving the phase-accumulator counter's
// enable, increment and reset pulse.
// Optional feature macro: SWEEP_TRIANGLE_EN -- in repeat mode the sweep
// bounces between endpoints without a LOAD/cnt_rst restart.
//
// Handshake: a config word is taken on any cycle where cfg_valid && cfg_ready;
// cfg_ready is high only while IDLE and never depends on cfg_valid.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int WIDTH   = SWEEP_WIDTH,
  parameter int DWELL_W = SWEEP_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_f_start,
  input  logic [WIDTH-1:0]   cfg_f_stop,
  input  logic [WIDTH-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_repeat,
  input  logic               start,
  input  logic               abort,
  output logic               cnt_rst,
  output logic               cnt_en,
  output logic [WIDTH-1:0]   cnt_incr,
  output logic               busy,
  output logic               done,
  output logic               dir_down,
  output logic [1:0]         state_dbg
);

  sweep_state_t     state, state_nxt;
  sweep_cfg_t       cfg;
  logic [WIDTH-1:0] incr_q;
  logic [WIDTH-1:0] incr_next;
  logic             cfg_take;
  logic             incr_from_start;
  logic             incr_from_step;
  logic             timer_load;
  logic             timer_en;
  logic             timer_expire;
  logic             sweep_end;
`ifdef SWEEP_TRIANGLE_EN
  logic             bounce;
  logic [WIDTH-1:0] incr_bounce;
`endif

  assign cfg_ready = (state == IDLE) && !rst;
  assign cfg_take  = cfg_valid && cfg_ready;
  assign sweep_end = (incr_q == cfg.f_stop) || (cfg.step == '0);
  assign incr_next = step_toward(incr_q, cfg.f_stop, cfg.step, cfg.dir_down);
`ifdef SWEEP_TRIANGLE_EN
  // At an endpoint the next value heads back toward the old start.
  assign incr_bounce = step_toward(incr_q, cfg.f_start, cfg.step, ~cfg.dir_down);
`endif

  // Timer runs only in RUN; an abort freezes it so no expiry is acted on.
  assign timer_en = (state == RUN) && !abort;

  assign cnt_incr  = incr_q;
  assign dir_down  = cfg.dir_down;
  assign state_dbg = state;

  dwell_timer #(.W(DWELL_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .value  (cfg.dwell),
    .en     (timer_en),
    .expire (timer_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode plus control strobes for the datapath and outputs.
  always_comb begin
    state_nxt       = state;
    incr_from_start = 1'b0;
    incr_from_step  = 1'b0;
    timer_load      = 1'b0;
    done            = 1'b0;
    cnt_rst         = 1'b0;
    cnt_en          = 1'b0;
    busy            = 1'b1;
`ifdef SWEEP_TRIANGLE_EN
    bounce          = 1'b0;
`endif
    case (state)
      IDLE: begin
        busy = 1'b0;
        // A config handshake in the same cycle defers start by one cycle.
        if (!abort && !cfg_take && start) state_nxt = LOAD;
      end
      LOAD: begin
        cnt_rst = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          incr_from_start = 1'b1;
          timer_load      = 1'b1;
          state_nxt       = RUN;
        end
      end
      RUN: begin
        cnt_en = 1'b1;
        if (abort)             state_nxt = IDLE;
        else if (timer_expire) state_nxt = STEP;
      end
      STEP: begin
        cnt_en = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (sweep_end) begin
          done = 1'b1;
          if (cfg.repeat_mode) begin
`ifdef SWEEP_TRIANGLE_EN
            bounce     = 1'b1;
            timer_load = 1'b1;
            state_nxt  = RUN;
`else
            state_nxt  = LOAD;
`endif
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          incr_from_step = 1'b1;
          timer_load     = 1'b1;
          state_nxt      = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Config capture and increment register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg    <= '0;
      incr_q <= '0;
    end else begin
      if (cfg_take) begin
        cfg.f_start     <= cfg_f_start;
        cfg.f_stop      <= cfg_f_stop;
        cfg.step        <= cfg_step;
        cfg.dwell       <= cfg_dwell;
        cfg.repeat_mode <= cfg_repeat;
        cfg.dir_down    <= (cfg_f_stop < cfg_f_start);
      end
      if (incr_from_start)     incr_q <= cfg.f_start;
      else if (incr_from_step) incr_q <= incr_next;
`ifdef SWEEP_TRIANGLE_EN
      if (bounce) begin
        incr_q       <= incr_bounce;
        cfg.f_start  <= cfg.f_stop;
        cfg.f_stop   <= cfg.f_start;
        cfg.dir_down <= ~cfg.dir_down;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl. Expected per-cycle output vectors are
// queued by hand and compared cycle by cycle after each rising edge.
module tb_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_f_start;
  logic [7:0]  cfg_f_stop;
  logic [7:0]  cfg_step;
  logic [15:0] cfg_dwell;
  logic        cfg_repeat;
  logic        start;
  logic        abort;
  logic        cnt_rst;
  logic        cnt_en;
  logic [7:0]  cnt_incr;
  logic        busy;
  logic        done;
  logic        dir_down;
  logic [1:0]  state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  // {cfg_ready, busy, done, cnt_rst, cnt_en, cnt_incr}
  logic [12:0] exp_q[$];

`ifdef SWEEP_TRIANGLE_EN
  localparam logic [7:0] REP_END = 8'd2;
`else
  localparam logic [7:0] REP_END = 8'd3;
`endif

  sweep_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_f_start (cfg_f_start),
    .cfg_f_stop  (cfg_f_stop),
    .cfg_step    (cfg_step),
    .cfg_dwell   (cfg_dwell),
    .cfg_repeat  (cfg_repeat),
    .start       (start),
    .abort       (abort),
    .cnt_rst     (cnt_rst),
    .cnt_en      (cnt_en),
    .cnt_incr    (cnt_incr),
    .busy        (busy),
    .done        (done),
    .dir_down    (dir_down),
    .state_dbg   (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {cfg_ready, busy, done, cnt_rst, cnt_en, cnt_incr};
  endfunction

  // Queue one expected cycle; cfg_ready mirrors !busy outside reset.
  task automatic push(input logic b, input logic d, input logic r, input logic e, input logic [7:0] incr);
    exp_q.push_back({~b, b, d, r, e, incr});
  endtask

  // Step through the queued expectations. For the first noise_n cycles the
  // inputs carry start and cfg_valid with junk config to show both are ignored.
  task automatic drain(input string tag, input int noise_n);
    logic [12:0] e;
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d]", tag, i), {19'd0, outs()}, {19'd0, e});
      if (i < noise_n) begin
        cfg_valid   = 1'b1;
        start       = 1'b1;
        cfg_f_start = 8'($urandom_range(0, 255));
        cfg_f_stop  = 8'($urandom_range(0, 255));
        cfg_step    = 8'($urandom_range(0, 255));
        cfg_dwell   = 16'($urandom_range(0, 7));
      end else begin
        cfg_valid = 1'b0;
        start     = 1'b0;
      end
      i++;
    end
  endtask

  task automatic load_cfg(input logic [7:0] fs, input logic [7:0] fe, input logic [7:0] st,
                          input logic [15:0] dw, input logic rp);
    cfg_valid   = 1'b1;
    cfg_f_start = fs;
    cfg_f_stop  = fe;
    cfg_step    = st;
    cfg_dwell   = dw;
    cfg_repeat  = rp;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_f_start = '0; cfg_f_stop = '0; cfg_step = '0;
    cfg_dwell = '0; cfg_repeat = 1'b0; start = 1'b0; abort = 1'b0;

    // Reset values.
    tick(); tick();
    chk("rst_outs", {19'd0, outs()}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    chk("rst_dir", {31'd0, dir_down}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_outs", {19'd0, outs()}, {19'd0, 13'h1000});

    // Up sweep 4 -> 7 -> 10, dwell 2.
    load_cfg(8'd4, 8'd10, 8'd3, 16'd2, 1'b0);
    chk("up_dir", {31'd0, dir_down}, 32'd0);
    start = 1'b1;
    push(1, 0, 1, 0, 8'd0);
    push(1, 0, 0, 1, 8'd4);  push(1, 0, 0, 1, 8'd4);  push(1, 0, 0, 1, 8'd4);
    push(1, 0, 0, 1, 8'd7);  push(1, 0, 0, 1, 8'd7);  push(1, 0, 0, 1, 8'd7);
    push(1, 0, 0, 1, 8'd10); push(1, 0, 0, 1, 8'd10); push(1, 1, 0, 1, 8'd10);
    push(0, 0, 0, 0, 8'd10); push(0, 0, 0, 0, 8'd10);
    drain("up", 0);

    // Clamped down sweep 200 -> 100 -> 5, with start/cfg_valid noise while busy.
    load_cfg(8'd200, 8'd5, 8'd100, 16'd1, 1'b0);
    chk("down_dir", {31'd0, dir_down}, 32'd1);
    start = 1'b1;
    push(1, 0, 1, 0, 8'd10);
    push(1, 0, 0, 1, 8'd200); push(1, 0, 0, 1, 8'd200);
    push(1, 0, 0, 1, 8'd100); push(1, 0, 0, 1, 8'd100);
    push(1, 0, 0, 1, 8'd5);   push(1, 1, 0, 1, 8'd5);
    push(0, 0, 0, 0, 8'd5);
    drain("down", 6);
    chk("down_dir_kept", {31'd0, dir_down}, 32'd1);

    // Repeat mode 1..3, ended with an abort.
    load_cfg(8'd1, 8'd3, 8'd1, 16'd1, 1'b1);
    start = 1'b1;
    push(1, 0, 1, 0, 8'd5);
    push(1, 0, 0, 1, 8'd1); push(1, 0, 0, 1, 8'd1);
    push(1, 0, 0, 1, 8'd2); push(1, 0, 0, 1, 8'd2);
    push(1, 0, 0, 1, 8'd3); push(1, 1, 0, 1, 8'd3);
`ifdef SWEEP_TRIANGLE_EN
    push(1, 0, 0, 1, 8'd2); push(1, 0, 0, 1, 8'd2);
    push(1, 0, 0, 1, 8'd1); push(1, 1, 0, 1, 8'd1);
    push(1, 0, 0, 1, 8'd2); push(1, 0, 0, 1, 8'd2);
    push(1, 0, 0, 1, 8'd3); push(1, 1, 0, 1, 8'd3);
    push(1, 0, 0, 1, 8'd2);
`else
    push(1, 0, 1, 0, 8'd3);
    push(1, 0, 0, 1, 8'd1); push(1, 0, 0, 1, 8'd1);
    push(1, 0, 0, 1, 8'd2); push(1, 0, 0, 1, 8'd2);
    push(1, 0, 0, 1, 8'd3); push(1, 1, 0, 1, 8'd3);
    push(1, 0, 1, 0, 8'd3);
`endif
    drain("rep", 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("rep_abort", {19'd0, outs()}, {19'd0, 5'b10000, REP_END});

    // Abort in RUN at value 7, then abort+start together in IDLE.
    load_cfg(8'd7, 8'd9, 8'd1, 16'd4, 1'b0);
    start = 1'b1;
    push(1, 0, 1, 0, REP_END);
    push(1, 0, 0, 1, 8'd7); push(1, 0, 0, 1, 8'd7);
    drain("abort_run", 0);
    abort = 1'b1;
    tick();
    chk("abort_outs", {19'd0, outs()}, {19'd0, 13'h1007});
    chk("abort_state", {30'd0, state_dbg}, 32'd0);
    start = 1'b1;
    tick();
    chk("abort_start_outs", {19'd0, outs()}, {19'd0, 13'h1007});
    chk("abort_start_state", {30'd0, state_dbg}, 32'd0);
    abort = 1'b0; start = 1'b0;

    // start with cfg handshake in the same cycle; step = 0, dwell = 0.
    start = 1'b1;
    load_cfg(8'd20, 8'd30, 8'd0, 16'd0, 1'b0);
    chk("cfg_start_idle", {19'd0, outs()}, {19'd0, 13'h1007});
    push(1, 0, 1, 0, 8'd7);
    push(1, 0, 0, 1, 8'd20); push(1, 1, 0, 1, 8'd20);
    push(0, 0, 0, 0, 8'd20);
    drain("step0", 0);

    // f_start == f_stop, dwell = 0.
    load_cfg(8'd9, 8'd9, 8'd2, 16'd0, 1'b0);
    start = 1'b1;
    push(1, 0, 1, 0, 8'd20);
    push(1, 0, 0, 1, 8'd9); push(1, 1, 0, 1, 8'd9);
    push(0, 0, 0, 0, 8'd9);
    drain("same", 0);

    // Reset during STEP, then start with cleared config.
    load_cfg(8'd50, 8'd60, 8'd5, 16'd1, 1'b0);
    start = 1'b1;
    push(1, 0, 1, 0, 8'd9);
    push(1, 0, 0, 1, 8'd50); push(1, 0, 0, 1, 8'd50);
    drain("pre_rst", 0);
    chk("pre_rst_state", {30'd0, state_dbg}, 32'd3);
    rst = 1'b1;
    tick();
    chk("mid_rst_outs", {19'd0, outs()}, 32'd0);
    chk("mid_rst_state", {30'd0, state_dbg}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", {19'd0, outs()}, {19'd0, 13'h1000});
    start = 1'b1;
    push(1, 0, 1, 0, 8'd0);
    push(1, 0, 0, 1, 8'd0); push(1, 1, 0, 1, 8'd0);
    push(0, 0, 0, 0, 8'd0);
    drain("zero", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
